// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: opcodes, flag bit positions and datapath defaults.
package cpu_pkg;

    localparam int DEF_DW = 16;
    localparam int DEF_RW = 4;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX->MEM handshake bundle. master = EX producer / MEM consumer side, slave = the pipeline stage.
interface ex_mem_stage_if #(
    parameter int DW = 16,
    parameter int RW = 4
);
    logic          ex_valid;
    logic          ex_ready;
    logic [3:0]    ex_opcode;
    logic [DW-1:0] ex_result;
    logic          ex_v;
    logic [RW-1:0] ex_rd;
    logic          ex_wr_en;
    logic          ex_sat;

    logic          mem_valid;
    logic          mem_ready;
    logic [DW-1:0] mem_result;
    logic [RW-1:0] mem_rd;
    logic          mem_wr_en;

    modport master (
        output ex_valid, ex_opcode, ex_result, ex_v, ex_rd, ex_wr_en, ex_sat, mem_ready,
        input  ex_ready, mem_valid, mem_result, mem_rd, mem_wr_en
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_result, ex_v, ex_rd, ex_wr_en, ex_sat, mem_ready,
        output ex_ready, mem_valid, mem_result, mem_rd, mem_wr_en
    );
endinterface

// File: rtl/ex_mem_stage_flag_update.sv
// Next-state Z/V/N flags for one instruction; combinational, 0 cycles.
// No handshake: the caller decides when flags_d is committed.
module flag_update
    import cpu_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] result,
    input  logic          v,
    input  logic [2:0]    flags_q,
    output logic [2:0]    flags_d
);
    always_comb begin
        flags_d = flags_q;
        case (opcode)
            OP_ADD, OP_SUB: begin
                flags_d[FLAG_Z] = (result == '0);
                flags_d[FLAG_V] = v;
                flags_d[FLAG_N] = result[DW-1];
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                flags_d[FLAG_Z] = (result == '0);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register plus architectural Z/V/N flags; optional PADDSB saturation counter (SAT_STATS_EN).
// Latency 1 cycle, full throughput; stalls EX (ex_ready=0) while MEM holds back a valid entry, flush squashes.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int RW = DEF_RW
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_mem_stage_if.slave bus,
    input  logic         flush,
    output logic [2:0]   flags,
    output logic [15:0]  sat_count
);
    logic          mem_valid_q;
    logic [DW-1:0] result_q;
    logic [RW-1:0] rd_q;
    logic          wr_en_q;
    logic [2:0]    flags_q;
    logic [2:0]    flags_d;
    logic          ex_ready;
    logic          cap;

    assign ex_ready = ~mem_valid_q | bus.mem_ready;
    assign cap      = bus.ex_valid & ex_ready & ~flush;

    flag_update #(.DW(DW)) u_flag_update (
        .opcode  (bus.ex_opcode),
        .result  (bus.ex_result),
        .v       (bus.ex_v),
        .flags_q (flags_q),
        .flags_d (flags_d)
    );

    // Flush also drops an entry MEM is still holding, not just the incoming one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_valid_q <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
            wr_en_q     <= 1'b0;
            flags_q     <= 3'b000;
        end else if (flush) begin
            mem_valid_q <= 1'b0;
        end else if (cap) begin
            mem_valid_q <= 1'b1;
            result_q    <= bus.ex_result;
            rd_q        <= bus.ex_rd;
            wr_en_q     <= bus.ex_wr_en;
            flags_q     <= flags_d;
        end else if (bus.mem_ready && mem_valid_q) begin
            mem_valid_q <= 1'b0;
        end
    end

`ifdef SAT_STATS_EN
    logic [15:0] sat_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_q <= '0;
        end else if (cap && bus.ex_opcode == OP_PADDSB && bus.ex_sat && sat_q != 16'hFFFF) begin
            sat_q <= sat_q + 16'd1;
        end
    end

    assign sat_count = sat_q;
`else
    logic unused_sat;

    assign unused_sat = bus.ex_sat;
    assign sat_count  = '0;
`endif

    assign bus.ex_ready   = ex_ready;
    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_result = result_q;
    assign bus.mem_rd     = rd_q;
    assign bus.mem_wr_en  = mem_valid_q & wr_en_q;
    assign flags          = flags_q;
endmodule
